// File: rtl/logic_slice_sequencer_if.sv
// Request/result bundle for logic_slice_sequencer.
// The master side is the ALU operation decoder / result consumer; the slave is the sequencer.
interface logic_slice_sequencer_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] in_0;
  logic [W-1:0] in_1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;

  modport master (
    output in_valid, op, in_0, in_1, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  in_valid, op, in_0, in_1, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/logic_slice_sequencer.sv
// Bitwise logic path of the ALU, evaluated one S-bit slice per cycle on a
// single shared slice of gates, LSB slice first.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; in_ready = 1
// RUN   | one slice per cycle from the captured operands, idx = slice
// DONE  | result/zero held; out_valid = 1 until out_ready
module logic_slice_sequencer #(
  parameter int W = 64,
  parameter int S = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  logic_slice_sequencer_if.slave bus
);

  localparam int N  = W / S;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [2:0]    op_q;
  logic [W-1:0]  in0_q;
  logic [W-1:0]  in1_q;
  logic [W-1:0]  result_q;
  logic [IW-1:0] idx_q;

  logic [S-1:0]  sl_a;
  logic [S-1:0]  sl_b;
  logic [S-1:0]  sl_y;
  logic          accept;
  logic          last_slice;
  logic          release_out;

  assign accept      = (state_q == IDLE) && bus.in_valid;
  assign last_slice  = (idx_q == IDX_LAST);
  assign release_out = (state_q == DONE) && bus.out_ready;

  // Handshake outputs come from the state register only, no input-to-output paths.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
  assign bus.zero      = ~|result_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)      state_d = RUN;
      RUN:     if (last_slice)  state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands for the current slice always come from the captured copies,
  // so the requester may change its inputs as soon as it has been accepted.
  assign sl_a = in0_q[idx_q * S +: S];
  assign sl_b = in1_q[idx_q * S +: S];

  // The single shared slice of word gates.
  always_comb begin
    sl_y = '0;
    case (op_q)
      3'b000: sl_y = sl_a & sl_b;
      3'b001: sl_y = sl_a | sl_b;
      3'b010: sl_y = sl_a ^ sl_b;
      3'b011: sl_y = ~(sl_a | sl_b);
      3'b100: sl_y = ~(sl_a & sl_b);
      3'b101: sl_y = ~(sl_a ^ sl_b);
      3'b110: sl_y = ~sl_a;
      3'b111: sl_y = sl_a;
      default: sl_y = '0;
    endcase
  end

  // Capture on accept, then fill the result one slice per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      in0_q    <= '0;
      in1_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
    end else if (accept) begin
      op_q     <= bus.op;
      in0_q    <= bus.in_0;
      in1_q    <= bus.in_1;
      result_q <= '0;
      idx_q    <= '0;
    end else if (state_q == RUN) begin
      result_q[idx_q * S +: S] <= sl_y;
      idx_q <= last_slice ? '0 : idx_q + IW'(1);
    end
  end

endmodule
